// File: rtl/uart_pkg.sv
// Shared UART types: byte width and byte type used by the receive and transmit sides.
package uart_pkg;
  localparam int unsigned UartDataW = 8;
  typedef logic [UartDataW-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: byte strobe in from the receiver, valid/ready stream and status out.
interface uart_rx_fifo_if #(parameter int unsigned Depth = 16);
  import uart_pkg::*;
  localparam int unsigned AddrW = $clog2(Depth);

  uart_byte_t       rx_data_i;
  logic             rx_valid_i;
  uart_byte_t       data_o;
  logic             valid_o;
  logic             ready_i;
  logic [AddrW:0]   level_o;
  logic             overrun_o;
  logic             overrun_clr_i;

  modport master (
    output rx_data_i, rx_valid_i, ready_i, overrun_clr_i,
    input  data_o, valid_o, level_o, overrun_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i, ready_i, overrun_clr_i,
    output data_o, valid_o, level_o, overrun_o
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Depth x byte register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  uart_byte_t               wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output uart_byte_t               rdata
);
  uart_byte_t mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures byte strobes into a circular buffer, first-word fall-through
// stream out, fill level and sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: Depth must be a power of two and >= 2");
  end

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            overrun;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            overflow;
  uart_byte_t      rd_data;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]) && (wr_ptr[AddrW] != rd_ptr[AddrW]);
  assign pop      = !empty && bus.ready_i;
  // A pop in the same cycle frees a slot, so a full buffer can still accept the byte.
  assign push     = bus.rx_valid_i && (!full || pop);
  assign overflow = bus.rx_valid_i && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
    end
  end

  // New overflow beats a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  overrun <= 1'b0;
    else if (overflow)          overrun <= 1'b1;
    else if (bus.overrun_clr_i) overrun <= 1'b0;
  end

  uart_fifo_mem #(.Depth(Depth)) u_mem (
    .clk   (clk_i),
    .we    (push && !rst_i),
    .waddr (wr_ptr[AddrW-1:0]),
    .wdata (bus.rx_data_i),
    .raddr (rd_ptr[AddrW-1:0]),
    .rdata (rd_data)
  );

  assign bus.data_o    = empty ? '0 : rd_data;
  assign bus.valid_o   = !empty;
  assign bus.level_o   = wr_ptr - rd_ptr;
  assign bus.overrun_o = overrun;
endmodule
